axi4_periph_bridge: RTL and testbench
=====================================

Name: axi4_periph_bridge

Overview:
AXI4 slave that terminates the data-port AXI master and drives a simple request/ack peripheral register bus (UART, SPI, GPIO, timers).
- Serialises one AXI transaction at a time.
- Supports INCR/FIXED bursts one beat per peripheral access.
- Returns B/R responses with echoed ID.
- Sits between the data-port AXI bridge and the peripheral address decoder.

Parameters:
- AXI_ID_W, 4: width of all AXI ID fields.
- TIMEOUT_CYCLES, 255: cycles to wait for periph_ack_i before forcing an error; used only when the optional feature is compiled in.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- axi_awvalid_i/axi_awready_o  in/out  1  AW handshake
- axi_awaddr_i  in  32  write address
- axi_awid_i  in  AXI_ID_W  write ID
- axi_awlen_i  in  8  beats minus one
- axi_awburst_i  in  2  burst type
- axi_wvalid_i/axi_wready_o  in/out  1  W handshake
- axi_wdata_i  in  32  write data
- axi_wstrb_i  in  4  byte strobes
- axi_wlast_i  in  1  last beat (ignored)
- axi_bvalid_o/axi_bready_i  out/in  1  B handshake
- axi_bresp_o  out  2  write response
- axi_bid_o  out  AXI_ID_W  write response ID
- axi_arvalid_i/axi_arready_o  in/out  1  AR handshake
- axi_araddr_i  in  32  read address
- axi_arid_i  in  AXI_ID_W  read ID
- axi_arlen_i  in  8  beats minus one
- axi_arburst_i  in  2  burst type
- axi_rvalid_o/axi_rready_i  out/in  1  R handshake
- axi_rdata_o  out  32  read data
- axi_rresp_o  out  2  read response
- axi_rid_o  out  AXI_ID_W  read ID
- axi_rlast_o  out  1  final read beat
- periph_addr_o  out  32  word-aligned peripheral address
- periph_data_wr_o  out  32  write data
- periph_wr_o  out  4  byte write strobes; non-zero means write request
- periph_rd_o  out  1  read request
- periph_data_rd_i  in  32  read data, valid with ack
- periph_ack_i  in  1  access complete
- periph_error_i  in  1  access error, valid with ack

Behaviour:
- Reset: state IDLE, all outputs 0, all registers cleared. Reset asserted mid-transaction aborts immediately with no strobe glitch and no response.
- FSM states: IDLE, WR_DATA, WR_ACCESS, WR_RESP, RD_ACCESS, RD_RESP.
- IDLE: awready_o=arready_o=1 only here.
  - If both AW and AR are valid, alternate priority using a last-grant flag (reset = read last, so write wins first). Only the granted channel's ready is asserted.
  - On grant, register addr {addr[31:2],2'b00}, id, len, burst; clear beat counter (8b) and error flag.
  - Next state: WR_DATA or RD_ACCESS.
- WR_DATA: wready_o=1. On W handshake, latch wdata/wstrb -> WR_ACCESS.
- WR_ACCESS: periph_wr_o=latched wstrb (a zero strobe still performs an access with periph_wr_o=0 treated as done immediately, no ack wait). Held stable until periph_ack_i.
  - On ack, OR periph_error_i into the error flag.
  - If beat==len -> WR_RESP, else increment beat, advance addr, -> WR_DATA.
- WR_RESP: bvalid_o=1, bresp = error flag ? 2'b10 : 2'b00, bid = latched id. Held until bready_i, then -> IDLE.
- RD_ACCESS: periph_rd_o=1 until ack. On ack, register rdata and rresp (error?2'b10:2'b00) -> RD_RESP.
- RD_RESP: rvalid_o=1, rlast_o=(beat==len), rid = latched id. Data and resp are stable until rready_i.
  - On handshake: if last -> IDLE, else beat+1, advance addr, -> RD_ACCESS.
- Address advance: FIXED (2'b00) holds the address. INCR/WRAP/reserved add 4, modulo 2^32 (0xFFFFFFFC -> 0x00000000).
- Latency, 0-wait peripheral (ack in same cycle as request): AW@N, W@N+1, periph_wr@N+2, bvalid@N+3. AR@N, periph_rd@N+1, rvalid@N+2.
- Peripheral never sees periph_wr_o and periph_rd_o together. Address and data are constant while a request is asserted.
- A new AW/AR is never accepted while any response is pending.

Optional Feature:
- Macro: AXI4_PERIPH_BRIDGE_TIMEOUT_EN.
- With it: an 8-bit+ counter runs in WR_ACCESS/RD_ACCESS and clears on ack or state exit. When the count reaches TIMEOUT_CYCLES, the access is completed as if ack arrived with periph_error_i=1: rdata=0, resp SLVERR, request dropped.
- Without it: the bridge waits indefinitely for ack, and no counter logic exists.

Decomposition:
- Shared package axi4_periph_pkg:
  - State encodings.
  - AXI_RESP_OKAY=2'b00, AXI_RESP_SLVERR=2'b10.
  - AXI_BURST_FIXED=2'b00, AXI_BURST_INCR=2'b01.
- No sub-module required; the timeout counter stays inline under the macro.

Test Plan:
- Single write awaddr=0x80000007, wdata=0xA5A5A5A5, wstrb=4'b0011, ack same cycle -> periph_addr=0x80000004, periph_wr=4'b0011 at N+2; bvalid at N+3 with bresp=00 and bid echoed.
- Read burst arlen=3 INCR at 0x100, ack delayed 2 cycles each -> periph_rd at 0x100/0x104/0x108/0x10C; 4 R beats; rlast only on the 4th; rready deasserted for 3 cycles holds rdata stable.
- AW and AR valid in the same cycle from reset -> write granted first, read granted next; repeat -> read granted first; never both readies high.
- Write burst awlen=1 with periph_error_i on beat 0 only -> single B with bresp=2'b10. FIXED burst keeps addr constant; INCR from 0xFFFFFFFC wraps to 0x0.
- rst_ni asserted during RD_ACCESS -> periph_rd_o, rvalid_o, and all readies drop asynchronously; after release a fresh read completes normally.
- With AXI4_PERIPH_BRIDGE_TIMEOUT_EN and TIMEOUT_CYCLES=16, no ack -> rvalid with rresp=2'b10 and rdata=0 after 16 cycles.

Source files
------------

// File: rtl/axi4_periph_pkg.sv
// Shared definitions for the AXI4-to-peripheral-bus bridge: FSM encodings,
// AXI response/burst codes and the burst address-advance helper.
package axi4_periph_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WR_DATA   = 3'd1;
  localparam logic [2:0] ST_WR_ACCESS = 3'd2;
  localparam logic [2:0] ST_WR_RESP   = 3'd3;
  localparam logic [2:0] ST_RD_ACCESS = 3'd4;
  localparam logic [2:0] ST_RD_RESP   = 3'd5;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

  // Only FIXED holds the address; WRAP and reserved codes step like INCR.
  function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                            input logic [1:0]  burst);
    return (burst == AXI_BURST_FIXED) ? addr : addr + 32'd4;
  endfunction

endpackage

// File: rtl/axi4_periph_bridge.sv
// AXI4 slave serialising one transaction at a time onto a req/ack peripheral bus.
// Optional ack timeout compiled in with `define AXI4_PERIPH_BRIDGE_TIMEOUT_EN.
//
// state        | meaning
// ST_IDLE      | accept one AW or AR (alternating priority when both valid)
// ST_WR_DATA   | wait for the next W beat
// ST_WR_ACCESS | periph_wr_o asserted until ack (zero strobe completes at once)
// ST_WR_RESP   | single B response for the whole burst
// ST_RD_ACCESS | periph_rd_o asserted until ack
// ST_RD_RESP   | R beat held until rready
module axi4_periph_bridge
  import axi4_periph_pkg::*;
#(
  parameter int AXI_ID_W       = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                axi_awvalid_i,
  output logic                axi_awready_o,
  input  logic [31:0]         axi_awaddr_i,
  input  logic [AXI_ID_W-1:0] axi_awid_i,
  input  logic [7:0]          axi_awlen_i,
  input  logic [1:0]          axi_awburst_i,
  input  logic                axi_wvalid_i,
  output logic                axi_wready_o,
  input  logic [31:0]         axi_wdata_i,
  input  logic [3:0]          axi_wstrb_i,
  input  logic                axi_wlast_i,
  output logic                axi_bvalid_o,
  input  logic                axi_bready_i,
  output logic [1:0]          axi_bresp_o,
  output logic [AXI_ID_W-1:0] axi_bid_o,
  input  logic                axi_arvalid_i,
  output logic                axi_arready_o,
  input  logic [31:0]         axi_araddr_i,
  input  logic [AXI_ID_W-1:0] axi_arid_i,
  input  logic [7:0]          axi_arlen_i,
  input  logic [1:0]          axi_arburst_i,
  output logic                axi_rvalid_o,
  input  logic                axi_rready_i,
  output logic [31:0]         axi_rdata_o,
  output logic [1:0]          axi_rresp_o,
  output logic [AXI_ID_W-1:0] axi_rid_o,
  output logic                axi_rlast_o,
  output logic [31:0]         periph_addr_o,
  output logic [31:0]         periph_data_wr_o,
  output logic [3:0]          periph_wr_o,
  output logic                periph_rd_o,
  input  logic [31:0]         periph_data_rd_i,
  input  logic                periph_ack_i,
  input  logic                periph_error_i
);

  logic [2:0]          state_q, state_d;
  logic [31:0]         addr_q, addr_d;
  logic [AXI_ID_W-1:0] id_q, id_d;
  logic [7:0]          len_q, len_d;
  logic [7:0]          beat_q, beat_d;
  logic [1:0]          burst_q, burst_d;
  logic                err_q, err_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [3:0]          wstrb_q, wstrb_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [1:0]          rresp_q, rresp_d;
  logic                last_wr_q, last_wr_d;
  logic                rdy_en_q;

  logic idle, grant_wr, last_beat;
  logic acc_tmo, acc_done, acc_err, wr_done;
  logic unused_ok;

  // rdy_en_q keeps both readies low while reset is asserted and for the first edge after.
  assign idle      = (state_q == ST_IDLE) && rdy_en_q;
  assign grant_wr  = last_wr_q ? (axi_awvalid_i && !axi_arvalid_i)
                               : (axi_awvalid_i || !axi_arvalid_i);
  assign last_beat = (beat_q == len_q);

`ifdef AXI4_PERIPH_BRIDGE_TIMEOUT_EN
  logic [15:0] tmo_q, tmo_d;

  assign acc_tmo = !periph_ack_i && (tmo_q == 16'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tmo_d = 16'd0;
    if ((state_q == ST_WR_ACCESS && !wr_done) || (state_q == ST_RD_ACCESS && !acc_done))
      tmo_d = tmo_q + 16'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) tmo_q <= 16'd0;
    else         tmo_q <= tmo_d;
  end

  assign unused_ok = ^{axi_wlast_i, axi_awaddr_i[1:0], axi_araddr_i[1:0]};
`else
  assign acc_tmo   = 1'b0;
  assign unused_ok = ^{axi_wlast_i, axi_awaddr_i[1:0], axi_araddr_i[1:0], 32'(TIMEOUT_CYCLES)};
`endif

  assign acc_done = periph_ack_i || acc_tmo;
  assign acc_err  = (periph_ack_i && periph_error_i) || acc_tmo;
  assign wr_done  = (wstrb_q == 4'd0) || acc_done;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    id_d      = id_q;
    len_d     = len_q;
    beat_d    = beat_q;
    burst_d   = burst_q;
    err_d     = err_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    last_wr_d = last_wr_q;
    case (state_q)
      ST_IDLE: begin
        if (idle && axi_awvalid_i && grant_wr) begin
          state_d   = ST_WR_DATA;
          addr_d    = {axi_awaddr_i[31:2], 2'b00};
          id_d      = axi_awid_i;
          len_d     = axi_awlen_i;
          burst_d   = axi_awburst_i;
          beat_d    = 8'd0;
          err_d     = 1'b0;
          last_wr_d = 1'b1;
        end else if (idle && axi_arvalid_i && !grant_wr) begin
          state_d   = ST_RD_ACCESS;
          addr_d    = {axi_araddr_i[31:2], 2'b00};
          id_d      = axi_arid_i;
          len_d     = axi_arlen_i;
          burst_d   = axi_arburst_i;
          beat_d    = 8'd0;
          err_d     = 1'b0;
          last_wr_d = 1'b0;
        end
      end
      ST_WR_DATA: begin
        if (axi_wvalid_i) begin
          wdata_d = axi_wdata_i;
          wstrb_d = axi_wstrb_i;
          state_d = ST_WR_ACCESS;
        end
      end
      ST_WR_ACCESS: begin
        if (wr_done) begin
          err_d = err_q || ((wstrb_q != 4'd0) && acc_err);
          if (last_beat) begin
            state_d = ST_WR_RESP;
          end else begin
            beat_d  = beat_q + 8'd1;
            addr_d  = next_addr(addr_q, burst_q);
            state_d = ST_WR_DATA;
          end
        end
      end
      ST_WR_RESP: begin
        if (axi_bready_i) state_d = ST_IDLE;
      end
      ST_RD_ACCESS: begin
        if (acc_done) begin
          rdata_d = periph_ack_i ? periph_data_rd_i : 32'd0;
          rresp_d = acc_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
          state_d = ST_RD_RESP;
        end
      end
      ST_RD_RESP: begin
        if (axi_rready_i) begin
          if (last_beat) begin
            state_d = ST_IDLE;
          end else begin
            beat_d  = beat_q + 8'd1;
            addr_d  = next_addr(addr_q, burst_q);
            state_d = ST_RD_ACCESS;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      addr_q    <= 32'd0;
      id_q      <= '0;
      len_q     <= 8'd0;
      beat_q    <= 8'd0;
      burst_q   <= 2'b00;
      err_q     <= 1'b0;
      wdata_q   <= 32'd0;
      wstrb_q   <= 4'd0;
      rdata_q   <= 32'd0;
      rresp_q   <= 2'b00;
      last_wr_q <= 1'b0;
      rdy_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      id_q      <= id_d;
      len_q     <= len_d;
      beat_q    <= beat_d;
      burst_q   <= burst_d;
      err_q     <= err_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      last_wr_q <= last_wr_d;
      rdy_en_q  <= 1'b1;
    end
  end

  assign axi_awready_o    = idle && grant_wr;
  assign axi_arready_o    = idle && !grant_wr;
  assign axi_wready_o     = (state_q == ST_WR_DATA);
  assign axi_bvalid_o     = (state_q == ST_WR_RESP);
  assign axi_bresp_o      = err_q ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
  assign axi_bid_o        = id_q;
  assign axi_rvalid_o     = (state_q == ST_RD_RESP);
  assign axi_rdata_o      = rdata_q;
  assign axi_rresp_o      = rresp_q;
  assign axi_rid_o        = id_q;
  assign axi_rlast_o      = (state_q == ST_RD_RESP) && last_beat;
  assign periph_addr_o    = addr_q;
  assign periph_data_wr_o = wdata_q;
  assign periph_wr_o      = (state_q == ST_WR_ACCESS) ? wstrb_q : 4'd0;
  assign periph_rd_o      = (state_q == ST_RD_ACCESS);

endmodule

// File: tb/tb_axi4_periph_bridge.sv
// Directed bench for axi4_periph_bridge; the timeout scenario runs only when
// AXI4_PERIPH_BRIDGE_TIMEOUT_EN is defined (bridge built with TIMEOUT_CYCLES=16).
module tb_axi4_periph_bridge;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        axi_awvalid_i, axi_awready_o;
  logic [31:0] axi_awaddr_i;
  logic [3:0]  axi_awid_i;
  logic [7:0]  axi_awlen_i;
  logic [1:0]  axi_awburst_i;
  logic        axi_wvalid_i, axi_wready_o;
  logic [31:0] axi_wdata_i;
  logic [3:0]  axi_wstrb_i;
  logic        axi_wlast_i;
  logic        axi_bvalid_o, axi_bready_i;
  logic [1:0]  axi_bresp_o;
  logic [3:0]  axi_bid_o;
  logic        axi_arvalid_i, axi_arready_o;
  logic [31:0] axi_araddr_i;
  logic [3:0]  axi_arid_i;
  logic [7:0]  axi_arlen_i;
  logic [1:0]  axi_arburst_i;
  logic        axi_rvalid_o, axi_rready_i;
  logic [31:0] axi_rdata_o;
  logic [1:0]  axi_rresp_o;
  logic [3:0]  axi_rid_o;
  logic        axi_rlast_o;
  logic [31:0] periph_addr_o, periph_data_wr_o;
  logic [3:0]  periph_wr_o;
  logic        periph_rd_o;
  logic [31:0] periph_data_rd_i;
  logic        periph_ack_i, periph_error_i;

  int passed = 0;
  int total  = 0;

  always #5 clk_i = ~clk_i;

  axi4_periph_bridge #(.AXI_ID_W(4), .TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .axi_awvalid_i(axi_awvalid_i), .axi_awready_o(axi_awready_o),
    .axi_awaddr_i(axi_awaddr_i), .axi_awid_i(axi_awid_i),
    .axi_awlen_i(axi_awlen_i), .axi_awburst_i(axi_awburst_i),
    .axi_wvalid_i(axi_wvalid_i), .axi_wready_o(axi_wready_o),
    .axi_wdata_i(axi_wdata_i), .axi_wstrb_i(axi_wstrb_i), .axi_wlast_i(axi_wlast_i),
    .axi_bvalid_o(axi_bvalid_o), .axi_bready_i(axi_bready_i),
    .axi_bresp_o(axi_bresp_o), .axi_bid_o(axi_bid_o),
    .axi_arvalid_i(axi_arvalid_i), .axi_arready_o(axi_arready_o),
    .axi_araddr_i(axi_araddr_i), .axi_arid_i(axi_arid_i),
    .axi_arlen_i(axi_arlen_i), .axi_arburst_i(axi_arburst_i),
    .axi_rvalid_o(axi_rvalid_o), .axi_rready_i(axi_rready_i),
    .axi_rdata_o(axi_rdata_o), .axi_rresp_o(axi_rresp_o),
    .axi_rid_o(axi_rid_o), .axi_rlast_o(axi_rlast_o),
    .periph_addr_o(periph_addr_o), .periph_data_wr_o(periph_data_wr_o),
    .periph_wr_o(periph_wr_o), .periph_rd_o(periph_rd_o),
    .periph_data_rd_i(periph_data_rd_i), .periph_ack_i(periph_ack_i),
    .periph_error_i(periph_error_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  initial begin
    rst_ni = 1'b0;
    axi_awvalid_i = 0; axi_awaddr_i = 0; axi_awid_i = 0; axi_awlen_i = 0; axi_awburst_i = 0;
    axi_wvalid_i = 0; axi_wdata_i = 0; axi_wstrb_i = 0; axi_wlast_i = 0; axi_bready_i = 0;
    axi_arvalid_i = 0; axi_araddr_i = 0; axi_arid_i = 0; axi_arlen_i = 0; axi_arburst_i = 0;
    axi_rready_i = 0; periph_data_rd_i = 0; periph_ack_i = 0; periph_error_i = 0;

    // Reset state
    #12;
    chk("rst_awready", {31'd0, axi_awready_o}, 0);
    chk("rst_arready", {31'd0, axi_arready_o}, 0);
    chk("rst_bvalid",  {31'd0, axi_bvalid_o}, 0);
    chk("rst_rvalid",  {31'd0, axi_rvalid_o}, 0);
    chk("rst_periph",  {27'd0, periph_wr_o, periph_rd_o}, 0);
    #10 rst_ni = 1'b1;
    tick();
    chk("idle_awready_first", {31'd0, axi_awready_o}, 1);
    chk("idle_arready_first", {31'd0, axi_arready_o}, 0);

    // Single write, zero-wait peripheral
    axi_awvalid_i = 1; axi_awaddr_i = 32'h8000_0007; axi_awid_i = 4'h5;
    axi_awlen_i = 0; axi_awburst_i = 2'b01; periph_ack_i = 1;
    #1 chk("w1_awready", {31'd0, axi_awready_o}, 1);
    tick();
    axi_awvalid_i = 0;
    chk("w1_wready", {31'd0, axi_wready_o}, 1);
    chk("w1_no_wr_yet", {28'd0, periph_wr_o}, 0);
    axi_wvalid_i = 1; axi_wdata_i = 32'hA5A5_A5A5; axi_wstrb_i = 4'b0011;
    tick();
    axi_wvalid_i = 0;
    chk("w1_periph_wr", {28'd0, periph_wr_o}, 4'b0011);
    chk("w1_periph_addr", periph_addr_o, 32'h8000_0004);
    chk("w1_periph_data", periph_data_wr_o, 32'hA5A5_A5A5);
    chk("w1_no_rd", {31'd0, periph_rd_o}, 0);
    tick();
    chk("w1_bvalid", {31'd0, axi_bvalid_o}, 1);
    chk("w1_bresp", {30'd0, axi_bresp_o}, 0);
    chk("w1_bid", {28'd0, axi_bid_o}, 4'h5);
    axi_bready_i = 1;
    tick();
    axi_bready_i = 0;
    chk("w1_bvalid_drop", {31'd0, axi_bvalid_o}, 0);
    chk("w1_pref_read_ar", {31'd0, axi_arready_o}, 1);
    chk("w1_pref_read_aw", {31'd0, axi_awready_o}, 0);

    // Read burst, 4 beats INCR at 0x100, ack two cycles late, rready stall on beat 1
    periph_ack_i = 0;
    axi_arvalid_i = 1; axi_araddr_i = 32'h100; axi_arid_i = 4'hA;
    axi_arlen_i = 3; axi_arburst_i = 2'b01;
    tick();
    axi_arvalid_i = 0;
    for (int i = 0; i < 4; i++) begin
      chk("r4_rd_req", {31'd0, periph_rd_o}, 1);
      chk("r4_addr", periph_addr_o, 32'h100 + 32'(4 * i));
      tick();
      chk("r4_rd_hold", {31'd0, periph_rd_o}, 1);
      chk("r4_addr_hold", periph_addr_o, 32'h100 + 32'(4 * i));
      periph_ack_i = 1; periph_data_rd_i = 32'h1000 + 32'(i);
      tick();
      periph_ack_i = 0; periph_data_rd_i = 32'hDEAD_BEEF;
      chk("r4_rvalid", {31'd0, axi_rvalid_o}, 1);
      chk("r4_rdata", axi_rdata_o, 32'h1000 + 32'(i));
      chk("r4_rlast", {31'd0, axi_rlast_o}, (i == 3) ? 1 : 0);
      chk("r4_rresp", {30'd0, axi_rresp_o}, 0);
      chk("r4_rid", {28'd0, axi_rid_o}, 4'hA);
      chk("r4_no_rd", {31'd0, periph_rd_o}, 0);
      if (i == 1) begin
        for (int s = 0; s < 3; s++) begin
          tick();
          chk("r4_stall_rvalid", {31'd0, axi_rvalid_o}, 1);
          chk("r4_stall_rdata", axi_rdata_o, 32'h1001);
        end
      end
      axi_rready_i = 1;
      tick();
      axi_rready_i = 0;
    end
    chk("r4_done_rvalid", {31'd0, axi_rvalid_o}, 0);
    chk("r4_done_awready", {31'd0, axi_awready_o}, 1);

    // AW and AR together after a read: write wins, then the read
    periph_ack_i = 1;
    axi_awvalid_i = 1; axi_awaddr_i = 32'h200; axi_awid_i = 4'h1; axi_awlen_i = 0; axi_awburst_i = 2'b01;
    axi_arvalid_i = 1; axi_araddr_i = 32'h300; axi_arid_i = 4'h2; axi_arlen_i = 0; axi_arburst_i = 2'b01;
    #1;
    chk("arb1_awready", {31'd0, axi_awready_o}, 1);
    chk("arb1_arready", {31'd0, axi_arready_o}, 0);
    tick();
    axi_awvalid_i = 0;
    chk("arb1_ar_blocked", {31'd0, axi_arready_o}, 0);
    axi_wvalid_i = 1; axi_wdata_i = 32'h1234_5678; axi_wstrb_i = 4'hF;
    tick();
    axi_wvalid_i = 0;
    chk("arb1_wr_addr", periph_addr_o, 32'h200);
    tick();
    chk("arb1_bvalid", {31'd0, axi_bvalid_o}, 1);
    chk("arb1_ar_blocked_resp", {31'd0, axi_arready_o}, 0);
    axi_bready_i = 1;
    tick();
    axi_bready_i = 0;
    chk("arb1_arready_next", {31'd0, axi_arready_o}, 1);
    chk("arb1_awready_next", {31'd0, axi_awready_o}, 0);
    periph_data_rd_i = 32'hCAFE_0300;
    tick();
    axi_arvalid_i = 0;
    chk("arb1_rd_addr", periph_addr_o, 32'h300);
    tick();
    chk("arb1_rvalid", {31'd0, axi_rvalid_o}, 1);
    chk("arb1_rid", {28'd0, axi_rid_o}, 4'h2);
    chk("arb1_rdata", axi_rdata_o, 32'hCAFE_0300);
    chk("arb1_rlast", {31'd0, axi_rlast_o}, 1);
    axi_rready_i = 1;
    tick();
    axi_rready_i = 0;

    // Write burst from 0xFFFFFFFC: error on beat 0 only, address wraps to 0
    axi_awvalid_i = 1; axi_awaddr_i = 32'hFFFF_FFFC; axi_awid_i = 4'h7; axi_awlen_i = 1; axi_awburst_i = 2'b01;
    tick();
    axi_awvalid_i = 0;
    axi_wvalid_i = 1; axi_wdata_i = 32'h11; axi_wstrb_i = 4'hF; periph_error_i = 1;
    tick();
    axi_wvalid_i = 0;
    chk("wb_addr0", periph_addr_o, 32'hFFFF_FFFC);
    chk("wb_wr0", {28'd0, periph_wr_o}, 4'hF);
    tick();
    periph_error_i = 0;
    chk("wb_no_b_mid", {31'd0, axi_bvalid_o}, 0);
    chk("wb_wready1", {31'd0, axi_wready_o}, 1);
    axi_wvalid_i = 1; axi_wdata_i = 32'h22;
    tick();
    axi_wvalid_i = 0;
    chk("wb_addr_wrap", periph_addr_o, 32'h0);
    chk("wb_data1", periph_data_wr_o, 32'h22);
    tick();
    chk("wb_bvalid", {31'd0, axi_bvalid_o}, 1);
    chk("wb_bresp", {30'd0, axi_bresp_o}, 2'b10);
    chk("wb_bid", {28'd0, axi_bid_o}, 4'h7);
    axi_bready_i = 1;
    tick();
    axi_bready_i = 0;

    // AW and AR together after a write: read wins; FIXED read burst
    axi_awvalid_i = 1; axi_awaddr_i = 32'h500; axi_awid_i = 4'h3; axi_awlen_i = 0; axi_awburst_i = 2'b01;
    axi_arvalid_i = 1; axi_araddr_i = 32'h40; axi_arid_i = 4'h4; axi_arlen_i = 1; axi_arburst_i = 2'b00;
    #1;
    chk("arb2_arready", {31'd0, axi_arready_o}, 1);
    chk("arb2_awready", {31'd0, axi_awready_o}, 0);
    periph_data_rd_i = 32'h55;
    tick();
    axi_arvalid_i = 0;
    chk("fx_addr0", periph_addr_o, 32'h40);
    tick();
    chk("fx_rdata0", axi_rdata_o, 32'h55);
    chk("fx_rlast0", {31'd0, axi_rlast_o}, 0);
    axi_rready_i = 1; periph_data_rd_i = 32'h66;
    tick();
    chk("fx_addr1", periph_addr_o, 32'h40);
    chk("fx_aw_blocked", {31'd0, axi_awready_o}, 0);
    tick();
    chk("fx_rdata1", axi_rdata_o, 32'h66);
    chk("fx_rlast1", {31'd0, axi_rlast_o}, 1);
    tick();
    axi_rready_i = 0;
    chk("arb2_awready_next", {31'd0, axi_awready_o}, 1);

    // Zero-strobe write completes without ack
    periph_ack_i = 0;
    tick();
    axi_awvalid_i = 0;
    axi_wvalid_i = 1; axi_wdata_i = 32'h99; axi_wstrb_i = 4'h0;
    tick();
    axi_wvalid_i = 0;
    chk("zs_periph_wr", {28'd0, periph_wr_o}, 0);
    chk("zs_addr", periph_addr_o, 32'h500);
    tick();
    chk("zs_bvalid", {31'd0, axi_bvalid_o}, 1);
    chk("zs_bresp", {30'd0, axi_bresp_o}, 0);
    axi_bready_i = 1;
    tick();
    axi_bready_i = 0;

    // Reset during RD_ACCESS, then a fresh read
    axi_arvalid_i = 1; axi_araddr_i = 32'h80; axi_arid_i = 4'h9; axi_arlen_i = 0; axi_arburst_i = 2'b01;
    tick();
    axi_arvalid_i = 0;
    chk("mr_rd_before", {31'd0, periph_rd_o}, 1);
    #1 rst_ni = 1'b0;
    #1;
    chk("mr_rd_drop", {31'd0, periph_rd_o}, 0);
    chk("mr_rvalid", {31'd0, axi_rvalid_o}, 0);
    chk("mr_readies", {30'd0, axi_awready_o, axi_arready_o}, 0);
    @(negedge clk_i) rst_ni = 1'b1;
    tick();
    axi_arvalid_i = 1; axi_araddr_i = 32'h84; axi_arid_i = 4'h3;
    periph_ack_i = 1; periph_data_rd_i = 32'h77;
    #1 chk("mr_arready", {31'd0, axi_arready_o}, 1);
    tick();
    axi_arvalid_i = 0;
    chk("mr_addr", periph_addr_o, 32'h84);
    tick();
    chk("mr_rdata", axi_rdata_o, 32'h77);
    chk("mr_rid", {28'd0, axi_rid_o}, 4'h3);
    chk("mr_rlast", {31'd0, axi_rlast_o}, 1);
    axi_rready_i = 1;
    tick();
    axi_rready_i = 0;

`ifdef AXI4_PERIPH_BRIDGE_TIMEOUT_EN
    begin
      int n;
      periph_ack_i = 0; periph_data_rd_i = 32'hFFFF_FFFF;
      axi_arvalid_i = 1; axi_araddr_i = 32'hC0; axi_arid_i = 4'h6;
      tick();
      axi_arvalid_i = 0;
      n = 0;
      while (axi_rvalid_o !== 1'b1 && n < 40) begin
        tick();
        n++;
      end
      chk("tmo_cycles", 32'(n), 32'd16);
      chk("tmo_rresp", {30'd0, axi_rresp_o}, 2'b10);
      chk("tmo_rdata", axi_rdata_o, 32'd0);
      chk("tmo_rd_dropped", {31'd0, periph_rd_o}, 0);
      axi_rready_i = 1;
      tick();
      axi_rready_i = 0;
    end
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
